// File: rtl/spike_packet_dispatcher.sv
// Spike packet receiver: filters 24-bit packets by cluster ID, buffers them in a FIFO and
// issues {src, neuron_idx} beats. Optional broadcast fan-out under DISPATCHER_BROADCAST_EN.
module spike_packet_dispatcher #(
   parameter int FIFO_DEPTH  = 8,
   parameter int NUM_NEURONS = 10,
   parameter int CNT_W       = 16
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          clear,
   input  logic [7:0]                    cluster_id,
   input  logic [23:0]                   packet_in,
   input  logic                          packet_valid,
   output logic                          packet_ready,
   output logic [11:0]                   out_src_addr,
   output logic [3:0]                    out_neuron_idx,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CNT_W-1:0]              drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          drained
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
   localparam logic [3:0]       LAST_IDX = 4'(NUM_NEURONS - 1);

   typedef struct packed {
      logic [11:0] src;
      logic [3:0]  idx;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE
`ifdef DISPATCHER_BROADCAST_EN
      , BCAST
`endif
   } state_e;

   entry_t             mem_q [FIFO_DEPTH];
   state_e             state_q, state_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d, remaining;
   logic [11:0]        out_src_q, out_src_d;
   logic [3:0]         out_idx_q, out_idx_d;
   logic               out_valid_q, out_valid_d;
   logic               packet_ready_q, packet_ready_d;
   logic               drained_q, drained_d;
   logic [CNT_W-1:0]   drop_count_q, drop_count_d;

   entry_t in_entry, head;
   logic   cluster_hit, idx_ok, accept, push, drop, pop, load, have_head;

   always_comb begin
      in_entry    = '{src: packet_in[23:12], idx: packet_in[3:0]};
      cluster_hit = (packet_in[11:4] == cluster_id);
`ifdef DISPATCHER_BROADCAST_EN
      idx_ok      = (packet_in[3:0] <= LAST_IDX) || (packet_in[3:0] == 4'hF);
`else
      idx_ok      = (packet_in[3:0] <= LAST_IDX);
`endif
      // A clear cycle refuses the packet outright, so it is neither buffered nor counted.
      accept = packet_valid & packet_ready_q & ~clear;
      push   = accept & cluster_hit & idx_ok;
      drop   = accept & ~(cluster_hit & idx_ok);

      state_d     = state_q;
      out_src_d   = out_src_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      pop         = 1'b0;
      load        = 1'b0;

      unique case (state_q)
         IDLE:  load = 1'b1;
         ISSUE: if (out_valid_q && out_ready) begin
            pop  = 1'b1;
            load = 1'b1;
         end
`ifdef DISPATCHER_BROADCAST_EN
         BCAST: if (out_valid_q && out_ready) begin
            if (out_idx_q == LAST_IDX) begin
               pop  = 1'b1;
               load = 1'b1;
            end else begin
               out_idx_d = out_idx_q + 4'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      remaining = pop  ? level_q - LVL_W'(1)  : level_q;

      // The head stays in the FIFO while on the output; when nothing older remains, the packet
      // being pushed this cycle is forwarded directly so an empty FIFO has one-cycle latency.
      have_head = (remaining != '0) || push;
      head      = (remaining != '0) ? mem_q[rd_ptr_d] : in_entry;

      if (load) begin
         if (have_head) begin
            out_valid_d = 1'b1;
            out_src_d   = head.src;
`ifdef DISPATCHER_BROADCAST_EN
            if (head.idx == 4'hF) begin
               state_d   = BCAST;
               out_idx_d = 4'd0;
            end else
`endif
            begin
               state_d   = ISSUE;
               out_idx_d = head.idx;
            end
         end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      drop_count_d = (drop && (drop_count_q != '1)) ? drop_count_q + CNT_W'(1) : drop_count_q;

      if (clear) begin
         state_d     = IDLE;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         level_d     = '0;
         out_valid_d = 1'b0;
         out_src_d   = '0;
         out_idx_d   = '0;
      end

      packet_ready_d = (level_d != FULL_LVL);
      drained_d      = (level_d == '0) && !out_valid_d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= IDLE;
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         level_q        <= '0;
         out_src_q      <= '0;
         out_idx_q      <= '0;
         out_valid_q    <= 1'b0;
         packet_ready_q <= 1'b1;
         drained_q      <= 1'b1;
         drop_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         level_q        <= level_d;
         out_src_q      <= out_src_d;
         out_idx_q      <= out_idx_d;
         out_valid_q    <= out_valid_d;
         packet_ready_q <= packet_ready_d;
         drained_q      <= drained_d;
         drop_count_q   <= drop_count_d;
      end
   end

   // NOTE: storage is not reset; entries are only read once the level says they were written.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= in_entry;
   end

   assign packet_ready   = packet_ready_q;
   assign out_src_addr   = out_src_q;
   assign out_neuron_idx = out_idx_q;
   assign out_valid      = out_valid_q;
   assign drop_count     = drop_count_q;
   assign fifo_level     = level_q;
   assign drained        = drained_q;

endmodule

// File: tb/tb_spike_packet_dispatcher.sv
// Scoreboard bench for spike_packet_dispatcher: directed scenarios plus random traffic
// checked against a packet-level queue model (honours DISPATCHER_BROADCAST_EN).
module tb_spike_packet_dispatcher;
   localparam int FIFO_DEPTH  = 8;
   localparam int NUM_NEURONS = 10;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        clear = 1'b0;
   logic [7:0]  cluster_id = 8'h02;
   logic [23:0] packet_in = '0;
   logic        packet_valid = 1'b0;
   logic        packet_ready;
   logic [11:0] out_src_addr;
   logic [3:0]  out_neuron_idx;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] drop_count;
   logic [3:0]  fifo_level;
   logic        drained;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   logic [15:0] exp_q[$];   // expected beats {src, idx}
   int          pkt_q[$];   // buffered packets: beats still owed for each
   logic [15:0] m_drop = '0;

   spike_packet_dispatcher #(
      .FIFO_DEPTH(FIFO_DEPTH), .NUM_NEURONS(NUM_NEURONS), .CNT_W(16)
   ) dut (
      .CLK(CLK), .RESET(RESET), .clear(clear), .cluster_id(cluster_id),
      .packet_in(packet_in), .packet_valid(packet_valid), .packet_ready(packet_ready),
      .out_src_addr(out_src_addr), .out_neuron_idx(out_neuron_idx), .out_valid(out_valid),
      .out_ready(out_ready), .drop_count(drop_count), .fifo_level(fifo_level), .drained(drained)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_accept(input logic [23:0] p);
      logic [3:0] idx;
      logic       hit;
      idx = p[3:0];
      hit = (p[11:4] == cluster_id);
      if (hit && int'(idx) < NUM_NEURONS) begin
         exp_q.push_back({p[23:12], idx});
         pkt_q.push_back(1);
      end
`ifdef DISPATCHER_BROADCAST_EN
      else if (hit && idx == 4'hF) begin
         for (int n = 0; n < NUM_NEURONS; n++) exp_q.push_back({p[23:12], 4'(n)});
         pkt_q.push_back(NUM_NEURONS);
      end
`endif
      else if (m_drop != 16'hFFFF) begin
         m_drop = m_drop + 16'd1;
      end
   endtask

   // Monitor: compare state left by the last edge, then advance the model for the next edge.
   always @(negedge CLK) begin
      logic [15:0] e;
      if (mon_en) begin
         check("level", 32'(fifo_level), pkt_q.size());
         check("out_valid", 32'(out_valid), 32'(pkt_q.size() != 0));
         check("packet_ready", 32'(packet_ready), 32'(pkt_q.size() != FIFO_DEPTH));
         check("drained", 32'(drained), 32'(pkt_q.size() == 0));
         check("drop_count", 32'(drop_count), 32'(m_drop));
      end
      if (RESET) begin
         exp_q.delete();
         pkt_q.delete();
         m_drop = '0;
      end else if (clear) begin
         exp_q.delete();
         pkt_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("beat_src", 32'(out_src_addr), 32'(e[15:4]));
               check("beat_idx", 32'(out_neuron_idx), 32'(e[3:0]));
            end
            if (pkt_q.size() != 0) begin
               pkt_q[0] = pkt_q[0] - 1;
               if (pkt_q[0] == 0) void'(pkt_q.pop_front());
            end
         end
         if (packet_valid && packet_ready) model_accept(packet_in);
      end
   end

   task automatic drive(input logic v, input logic [23:0] p, input logic r, input logic c);
      @(posedge CLK);
      #1;
      packet_valid = v;
      packet_in    = p;
      out_ready    = r;
      clear        = c;
   endtask

   initial begin
      logic [23:0] p;
      bit          done;

      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      mon_en = 1'b1;
      @(negedge CLK);
      check("rst_src", 32'(out_src_addr), 32'h0);
      check("rst_idx", 32'(out_neuron_idx), 32'h0);
      check("rst_drained", 32'(drained), 32'd1);
      check("rst_ready", 32'(packet_ready), 32'd1);

      // single packet, one-cycle latency
      drive(1, 24'h00A_021, 1, 0);
      drive(0, 24'h0, 1, 0);
      @(negedge CLK);
      check("t1_src", 32'(out_src_addr), 32'h00A);
      check("t1_idx", 32'(out_neuron_idx), 32'h1);
      drive(0, 24'h0, 1, 0);
      @(negedge CLK);
      check("t1_drained", 32'(drained), 32'd1);

      // filter: wrong cluster and out-of-range index
      drive(1, 24'h005_031, 1, 0);
      drive(1, 24'h005_02C, 1, 0);
      repeat (3) drive(0, 24'h0, 1, 0);
      check("t2_drop", 32'(drop_count), 32'd2);

      // backpressure until full, then 8 back-to-back beats
      for (int i = 0; i < 9; i++) drive(1, {12'(12'h100 + i), 8'h02, 4'(i)}, 0, 0);
      drive(0, 24'h0, 0, 0);
      @(negedge CLK);
      check("t3_level", 32'(fifo_level), 32'd8);
      check("t3_ready", 32'(packet_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 24'h0, 1, 0);
         @(negedge CLK);
         check("t3_b2b_valid", 32'(out_valid), 32'd1);
      end
      repeat (2) drive(0, 24'h0, 1, 0);

      // simultaneous push and pop at level 3, across a pointer wrap
      for (int i = 0; i < 3; i++) drive(1, {12'(12'h200 + i), 8'h02, 4'(i)}, 0, 0);
      for (int i = 0; i < 10; i++) begin
         drive(1, {12'(12'h300 + i), 8'h02, 4'(i % 10)}, 1, 0);
         @(negedge CLK);
         check("t4_level", 32'(fifo_level), 32'd3);
      end
      repeat (5) drive(0, 24'h0, 1, 0);

      // clear mid-beat at level 5; same-cycle packet is refused
      for (int i = 0; i < 5; i++) drive(1, {12'(12'h400 + i), 8'h02, 4'(i)}, 0, 0);
      drive(1, 24'h4FF_023, 1, 1);
      drive(0, 24'h0, 1, 0);
      @(negedge CLK);
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_level", 32'(fifo_level), 32'd0);
      check("t5_drained", 32'(drained), 32'd1);
      check("t5_drop", 32'(drop_count), 32'd2);

      // broadcast index
      drive(1, 24'h123_02F, 1, 0);
      repeat (14) drive(0, 24'h0, 1, 0);
`ifdef DISPATCHER_BROADCAST_EN
      check("t6_drop", 32'(drop_count), 32'd2);
`else
      check("t6_drop", 32'(drop_count), 32'd3);
`endif

      // random traffic with stalls and occasional clears
      for (int i = 0; i < 600; i++) begin
         p = 24'($urandom);
         if ($urandom_range(0, 3) != 0) p[11:4] = 8'h02;
         drive($urandom_range(0, 2) != 0, p, $urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0);
      end

      // drain, bounded
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         drive(0, 24'h0, 1, 0);
         @(negedge CLK);
         done = drained && (exp_q.size() == 0);
      end
      check("final_drained", 32'(done), 32'd1);
      check("sb_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
